// File: rtl/dmem_ls_pkg.sv
// Shared types and default stack bounds for the data-memory load/store unit.
// Opcode and state encodings live here so the bench and sub-modules agree.
package dmem_ls_pkg;

    localparam logic [7:0] STACK_BASE_DEF  = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'hC0;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_COPY  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } ls_op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_COPY_RD = 3'd2,
        ST_COPY_WR = 3'd3,
        ST_RESP    = 3'd4
    } ls_state_t;

    // A COPY of zero bytes is handled as a single-cycle EXEC like the simple ops.
    function automatic logic copy_needs_loop(ls_op_t op, logic [7:0] len);
        return (op == OP_COPY) && (len != 8'd0);
    endfunction

endpackage

// File: rtl/dmem_ls_unit_stack_ptr.sv
// Stack pointer register for the load/store unit.
// Grows downward from STACK_BASE; full once it has dropped below STACK_LIMIT.
module ls_stack_ptr
    import dmem_ls_pkg::*;
#(
    parameter logic [7:0] STACK_BASE  = STACK_BASE_DEF,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       push_ok,
    input  logic       pop_ok,
    output logic [7:0] sp,
    output logic       stk_full,
    output logic       stk_empty
);

    logic [7:0] sp_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sp_reg <= STACK_BASE;
        end else if (push_ok) begin
            sp_reg <= sp_reg - 8'd1;
        end else if (pop_ok) begin
            sp_reg <= sp_reg + 8'd1;
        end
    end

    assign sp        = sp_reg;
    assign stk_full  = (sp_reg < STACK_LIMIT);
    assign stk_empty = (sp_reg == STACK_BASE);

endmodule

// File: rtl/dmem_ls_unit.sv
// Load/store front end for a 256x8 data memory with combinational read.
// Handles LOAD/STORE/PUSH/POP in one EXEC cycle and COPY as a read/write byte loop.
module dmem_ls_unit
    import dmem_ls_pkg::*;
#(
    parameter logic [7:0] STACK_BASE  = STACK_BASE_DEF,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_dst,
    input  logic [7:0] req_len,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] sp,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);

    ls_state_t  state_reg;
    ls_op_t     op_reg;
    ls_op_t     req_op_cast;
    logic [7:0] addr_reg;
    logic [7:0] dst_reg;
    logic [7:0] len_reg;
    logic [7:0] data_reg;
    logic [7:0] idx_reg;
    logic [7:0] idx_next;
    logic [7:0] buf_reg;
    logic [7:0] rsp_data_reg;
    logic       rsp_err_reg;
    logic       wr_req;
    logic       stk_full;
    logic       stk_empty;
    logic       push_ok;
    logic       pop_ok;

    assign req_op_cast = ls_op_t'(req_op);
    assign idx_next    = idx_reg + 8'd1;

    assign push_ok = (state_reg == ST_EXEC) && (op_reg == OP_PUSH) && !stk_full;
    assign pop_ok  = (state_reg == ST_EXEC) && (op_reg == OP_POP)  && !stk_empty;

    ls_stack_ptr #(
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_stack_ptr (
        .clk       (clk),
        .srst      (reset),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .sp        (sp),
        .stk_full  (stk_full),
        .stk_empty (stk_empty)
    );

    // Memory port is a pure decode of the state and latched request fields.
    always_comb begin
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        wr_req    = 1'b0;
        case (state_reg)
            ST_EXEC: begin
                case (op_reg)
                    OP_LOAD: begin
                        mem_addr = addr_reg;
                    end
                    OP_STORE: begin
                        mem_addr  = addr_reg;
                        mem_wdata = data_reg;
                        wr_req    = 1'b1;
                    end
                    OP_PUSH: begin
                        if (!stk_full) begin
                            mem_addr  = sp;
                            mem_wdata = data_reg;
                            wr_req    = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (!stk_empty) begin
                            mem_addr = sp + 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            ST_COPY_RD: begin
                mem_addr = addr_reg + idx_reg;
            end
            ST_COPY_WR: begin
                mem_addr  = dst_reg + idx_reg;
                mem_wdata = buf_reg;
                wr_req    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A reset landing mid-COPY must not let the in-flight byte reach memory.
    assign mem_wr_en = wr_req && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_NOP;
            addr_reg     <= 8'h00;
            dst_reg      <= 8'h00;
            len_reg      <= 8'h00;
            data_reg     <= 8'h00;
            idx_reg      <= 8'h00;
            buf_reg      <= 8'h00;
            rsp_data_reg <= 8'h00;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg       <= req_op_cast;
                        addr_reg     <= req_addr;
                        dst_reg      <= req_dst;
                        len_reg      <= req_len;
                        data_reg     <= req_data;
                        idx_reg      <= 8'h00;
                        rsp_data_reg <= 8'h00;
                        rsp_err_reg  <= 1'b0;
                        state_reg    <= copy_needs_loop(req_op_cast, req_len) ?
                                        ST_COPY_RD : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (op_reg)
                        OP_LOAD: begin
                            rsp_data_reg <= mem_rdata;
                        end
                        OP_PUSH: begin
                            if (stk_full) begin
                                rsp_err_reg <= 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (stk_empty) begin
                                rsp_err_reg <= 1'b1;
                            end else begin
                                rsp_data_reg <= mem_rdata;
                            end
                        end
                        OP_NOP, OP_STORE, OP_COPY: begin
                        end
                        default: begin
                            rsp_err_reg <= 1'b1;
                        end
                    endcase
                    state_reg <= ST_RESP;
                end
                ST_COPY_RD: begin
                    buf_reg   <= mem_rdata;
                    state_reg <= ST_COPY_WR;
                end
                ST_COPY_WR: begin
                    idx_reg   <= idx_next;
                    state_reg <= (idx_next == len_reg) ? ST_RESP : ST_COPY_RD;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
